// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM states, data width and
// the clocks-per-bit calculation.
package uart_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    function automatic int calc_bit_cycles(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx line plus a falling-edge
// detector on the synchronized signal. All stages reset to the idle level (1).
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_sync,
    output logic fall
);

    logic [1:0] sync_reg;
    logic       prev_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= 2'b11;
            prev_reg <= 1'b1;
        end else begin
            sync_reg <= {sync_reg[0], rx};
            prev_reg <= sync_reg[1];
        end
    end

    assign rx_sync = sync_reg[1];
    assign fall    = prev_reg & ~sync_reg[1];

endmodule

// File: rtl/uart_rx_top.sv
// 8N1 UART receiver: mid-bit sampling FSM, cycle/bit counters and shift register.
// Optional macro UART_RX_FRAME_ERR_EN adds a one-clock frame_err pulse output.
module uart_rx_top
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic [DATA_W-1:0] data_rx,
    output logic              done_rx
`ifdef UART_RX_FRAME_ERR_EN
    ,
    output logic              frame_err
`endif
);

    localparam int BIT_CYCLES = calc_bit_cycles(CLK_FREQ, BAUD);
    localparam int CNT_W      = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CYCLES / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);

    logic rx_sync;
    logic fall;

    uart_rx_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .rx      (rx),
        .rx_sync (rx_sync),
        .fall    (fall)
    );

    rx_state_t         state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [2:0]        bit_reg, bit_next;
    logic [DATA_W-1:0] shift_reg, shift_next;
    logic [DATA_W-1:0] data_reg, data_next;
    logic              done_reg, done_next;
`ifdef UART_RX_FRAME_ERR_EN
    logic              frame_err_reg, frame_err_next;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            data_reg  <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            data_reg  <= data_next;
            done_reg  <= done_next;
        end
    end

`ifdef UART_RX_FRAME_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) frame_err_reg <= 1'b0;
        else     frame_err_reg <= frame_err_next;
    end
    assign frame_err = frame_err_reg;
`endif

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + 1'b1;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        data_next  = data_reg;
        done_next  = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
        frame_err_next = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (fall) state_next = START;
            end
            START: begin
                // Re-check the line at the middle of the start bit to reject glitches.
                if (cnt_reg == HALF_LAST) begin
                    cnt_next   = '0;
                    state_next = rx_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next   = '0;
                    shift_next = {rx_sync, shift_reg[DATA_W-1:1]};
                    bit_next   = bit_reg + 3'd1;
                    if (bit_reg == 3'd7) state_next = STOP;
                end
            end
            STOP: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                    if (rx_sync) begin
                        data_next = shift_reg;
                        done_next = 1'b1;
                    end else begin
`ifdef UART_RX_FRAME_ERR_EN
                        frame_err_next = 1'b1;
`endif
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign data_rx = data_reg;
    assign done_rx = done_reg;

endmodule

// File: tb/tb_uart_rx_top.sv
// Directed testbench for uart_rx_top at a shortened bit time (16 clocks/bit).
// Build with UART_RX_FRAME_ERR_EN defined to also check the frame_err output.
module tb_uart_rx_top;
    import uart_pkg::*;

    localparam int CLK_FREQ = 50_000_000;
    localparam int BAUD     = 3_125_000;
    localparam int BITC     = CLK_FREQ / BAUD;          // 16 clocks per bit
    localparam int LAT_NOM  = 2 + BITC / 2 + 9 * BITC;  // 154

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data_rx;
    logic       done_rx;
`ifdef UART_RX_FRAME_ERR_EN
    logic       frame_err;
    int         ferr_cnt = 0;
`endif

    uart_rx_top #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk     (clk),
        .rst     (rst),
        .rx      (rx),
        .data_rx (data_rx),
        .done_rx (done_rx)
`ifdef UART_RX_FRAME_ERR_EN
        ,
        .frame_err (frame_err)
`endif
    );

    always #10 clk = ~clk;

    int         checks    = 0;
    int         passes    = 0;
    int         cyc       = 0;
    int         done_cnt  = 0;
    int         done_cyc  = 0;
    int         width_err = 0;
    logic       done_prev = 1'b0;
    logic [7:0] got[$];

    always @(posedge clk) cyc++;

    // Pulse monitor: records every received byte and flags over-long pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (done_rx) begin
                done_cnt++;
                done_cyc = cyc;
                got.push_back(data_rx);
                $display("rx byte 0x%02h at cycle %0d", data_rx, cyc);
            end
            if (done_rx && done_prev) width_err++;
`ifdef UART_RX_FRAME_ERR_EN
            if (frame_err) ferr_cnt++;
`endif
        end
        done_prev = done_rx;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        repeat (BITC) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    int base;
    int t0;
    int lat;
    logic [7:0] mid;

    initial begin
        // Reset state
        repeat (4) @(negedge clk);
        check("reset_data", 32'(data_rx), 32'h00);
        check("reset_done", 32'(done_rx), 32'h0);
        check("reset_state", 32'(dut.state_reg), 32'(IDLE));
        rst = 1'b0;

        // Power-up with idle line
        idle(2000);
        check("powerup_data", 32'(data_rx), 32'h00);
        check("powerup_pulses", 32'(done_cnt), 32'd0);

        // Single frame 0xAC (bits 0,0,1,1,0,1,0,1) with latency window
        base = done_cnt;
        t0 = cyc;
        send_frame(8'hAC, 1'b1);
        idle(2 * BITC);
        lat = done_cyc - t0 - 1;
        $display("frame 0xAC latency %0d clocks", lat);
        check("ac_pulses", 32'(done_cnt - base), 32'd1);
        check("ac_data", 32'(data_rx), 32'hAC);
        check("ac_latency_in_window", 32'(lat >= LAT_NOM - 2 && lat <= LAT_NOM + 2), 32'd1);

        // Back-to-back frames with no idle gap
        base = done_cnt;
        send_frame(8'h55, 1'b1);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(2 * BITC);
        check("b2b_pulses", 32'(done_cnt - base), 32'd3);
        check("b2b_byte0", 32'(got[base]), 32'h55);
        check("b2b_byte1", 32'(got[base + 1]), 32'h00);
        check("b2b_byte2", 32'(got[base + 2]), 32'hFF);

        // Glitch shorter than half a bit
        base = done_cnt;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        idle(3 * BITC);
        check("glitch_no_pulse", 32'(done_cnt - base), 32'd0);
        check("glitch_state_idle", 32'(dut.state_reg), 32'(IDLE));
        send_frame(8'h3C, 1'b1);
        idle(2 * BITC);
        check("after_glitch_pulses", 32'(done_cnt - base), 32'd1);
        check("after_glitch_data", 32'(data_rx), 32'h3C);

        // Framing error: stop bit 0 after 0x81
        base = done_cnt;
        send_frame(8'h81, 1'b0);
        idle(2 * BITC);
        check("ferr_no_pulse", 32'(done_cnt - base), 32'd0);
        check("ferr_data_held", 32'(data_rx), 32'h3C);
`ifdef UART_RX_FRAME_ERR_EN
        check("ferr_pulse_count", 32'(ferr_cnt), 32'd1);
`endif

        // Reset asserted in the middle of data bit 4
        base = done_cnt;
        mid = 8'hF0;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(mid[i]);
        rx = mid[4];
        repeat (BITC / 2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("midrst_data_zero", 32'(data_rx), 32'h00);
        idle(3 * BITC);
        check("midrst_no_pulse", 32'(done_cnt - base), 32'd0);
        check("midrst_state_idle", 32'(dut.state_reg), 32'(IDLE));
        send_frame(8'hA5, 1'b1);
        idle(2 * BITC);
        check("a5_pulses", 32'(done_cnt - base), 32'd1);
        check("a5_data", 32'(data_rx), 32'hA5);

        check("done_width_one", 32'(width_err), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_top.md
# uart_rx_top

UART receiver for 8N1 serial frames, top level of the receive path. Oversamples the asynchronous `rx` line with the system clock and recovers each byte by sampling at mid-bit. Presents the byte on `data_rx` with a one-cycle `done_rx` strobe. Consumers sample `data_rx` on that strobe.

## Interface
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `BAUD`, default 9600: line rate in bit/s.
- `BIT_CYCLES`, default CLK_FREQ/BAUD (5208): clocks per bit, integer-truncated. Derived; not overridden independently.
- `clk` input, 1 bit: single system clock; all logic on the rising edge.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `rx` input, 1 bit: asynchronous serial line; idle high.
- `data_rx` output, 8 bits: last correctly framed byte; holds until the next good frame.
- `done_rx` output, 1 bit: one-clock pulse when `data_rx` is updated.

## Operation
- `rx` passes through a 2-flop synchronizer; the synchronizer resets to 1.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); no parity.
- State machine:
  - IDLE: wait for a falling edge of synchronized `rx`, then go to START.
  - START: count to BIT_CYCLES/2−1 (2603). If `rx` is still 0, go to DATA. Otherwise, on a glitch, return to IDLE with no output.
  - DATA: count to BIT_CYCLES−1 per bit, then sample. Shift the sample into the MSB of the shift register, moving earlier bits right. After bit index 7 is sampled, go to STOP.
  - STOP: count to BIT_CYCLES−1, then sample.
    - Sample 1: copy the shift register to `data_rx`, pulse `done_rx`, go to IDLE.
    - Sample 0 (framing error): discard the byte; `data_rx` is unchanged and `done_rx` stays low; go to IDLE.
- Counters:
  - Cycle counter is wide enough for BIT_CYCLES−1 (13 bits at defaults) and clears on every state change and every bit sample.
  - Bit index counter is 3 bits.
- Falling edges during START, DATA or STOP are ignored; only IDLE arms on an edge.
- After STOP the FSM returns to IDLE immediately, so a start bit directly following the stop-bit sample is accepted (back-to-back frames).

## Timing
- Reset values: `data_rx` = 8'h00, `done_rx` = 0, FSM = IDLE, all counters and the shift register = 0.
- Reset asserted mid-frame aborts the frame with no `done_rx`. `data_rx` returns to 0.
- `done_rx` width: exactly 1 clock.
- Latency from the first clock where raw `rx` is low to `done_rx` high: 2 (sync) + BIT_CYCLES/2 + 9·BIT_CYCLES clocks, ±2. At defaults this is about 49 478 clocks.
- `data_rx` changes on the same clock edge that raises `done_rx`.
- Sampling points sit at mid-bit, tolerating ±~4 % baud mismatch over a frame.

## Configuration
- `UART_RX_FRAME_ERR_EN` defined:
  - Adds output `frame_err` (1 bit, reset 0).
  - `frame_err` pulses for 1 clock when the stop bit samples 0, in the same position in time as `done_rx` would have pulsed.
- Not defined:
  - Port absent.
  - Framing errors are silently discarded.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum (IDLE, START, DATA, STOP);
  - a function computing clocks-per-bit from CLK_FREQ and BAUD;
  - the data width constant (8).
- One sub-module, `uart_rx_sync`: the 2-flop synchronizer plus falling-edge detector.
- FSM, counters and shift register live in `uart_rx_top`.

## Test plan
- Frame, 1 start bit then bits 0,0,1,1,0,1,0,1 then stop=1, at BIT_CYCLES·20 ns per bit with a 20 ns clock:
  - `data_rx` = 8'hAC;
  - one `done_rx` pulse within the latency window.
- Frames 8'h55, then 8'h00, then 8'hFF sent back-to-back with no idle gap: three `done_rx` pulses with matching bytes, in order.
- Glitch: `rx` low for 1000 clocks, then high:
  - no `done_rx`;
  - FSM back in IDLE;
  - a following 8'h3C frame is received correctly.
- Framing error, stop bit 0 after 8'h81:
  - no `done_rx`;
  - `data_rx` keeps its previous value;
  - with `UART_RX_FRAME_ERR_EN`, one `frame_err` pulse.
- Reset mid-frame: `rst` asserted during data bit 4 for 2 clocks, then a clean 8'hA5 frame:
  - `data_rx` = 0 after reset;
  - no pulse for the aborted frame;
  - 8'hA5 received.
- Power-up: `rx` held high for 100 000 clocks after reset: outputs stay 8'h00 and 0.
